mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving a processor (r0) and a loader (r1) shared access to one data memory.
// Size/alignment is checked on the request; every output comes straight from a flop.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req_i,
  input  logic                  r0_we_i,
  input  logic [1:0]            r0_size_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  output logic                  r0_gnt_o,
  output logic                  r0_err_o,
  output logic                  r0_rvalid_o,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  input  logic                  r1_req_i,
  input  logic                  r1_we_i,
  input  logic [1:0]            r1_size_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  output logic                  r1_gnt_o,
  output logic                  r1_err_o,
  output logic                  r1_rvalid_o,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [1:0]            mem_size_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  state_e                state_q, state_d;
  logic                  last_q, last_d, win_q, win_d, ld_q, ld_d;
  logic [1:0]            gnt_q, gnt_d, err_q, err_d, rvalid_q, rvalid_d;
  logic                  mem_re_q, mem_re_d, mem_we_q, mem_we_d, busy_q, busy_d;
  logic [1:0]            mem_size_q, mem_size_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  any_req, win, sel_we, illegal;
  logic [1:0]            sel_size;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  // On a tie the requester that did not win last time goes next
  assign any_req   = r0_req_i | r1_req_i;
  assign win       = (r0_req_i & r1_req_i) ? ~last_q : r1_req_i;
  assign sel_we    = win ? r1_we_i : r0_we_i;
  assign sel_size  = win ? r1_size_i : r0_size_i;
  assign sel_addr  = win ? r1_addr_i : r0_addr_i;
  assign sel_wdata = win ? r1_wdata_i : r0_wdata_i;
  assign illegal   = (sel_size == 2'b11) | ((sel_size == 2'b01) & sel_addr[0]) |
                     ((sel_size == 2'b10) & (|sel_addr[1:0]));
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    ld_d        = ld_q;
    gnt_d       = 2'b00;
    err_d       = 2'b00;
    rvalid_d    = 2'b00;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ISSUE;
          last_d      = win;
          win_d       = win;
          ld_d        = ~illegal & ~sel_we;
          gnt_d       = win ? 2'b10 : 2'b01;
          err_d       = illegal ? (win ? 2'b10 : 2'b01) : 2'b00;
          mem_re_d    = ~illegal & ~sel_we;
          mem_we_d    = ~illegal & sel_we;
          mem_size_d  = sel_size;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ISSUE: state_d = ld_q ? WAIT : IDLE;
      WAIT: begin
        state_d  = IDLE;
        rvalid_d = win_q ? 2'b10 : 2'b01;
        rdata0_d = win_q ? rdata0_q : mem_rdata_i;
        rdata1_d = win_q ? mem_rdata_i : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      ld_q        <= 1'b0;
      gnt_q       <= 2'b00;
      err_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      ld_q        <= ld_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end
  assign r0_gnt_o    = gnt_q[0];
  assign r1_gnt_o    = gnt_q[1];
  assign r0_err_o    = err_q[0];
  assign r1_err_o    = err_q[1];
  assign r0_rvalid_o = rvalid_q[0];
  assign r1_rvalid_o = rvalid_q[1];
  assign r0_rdata_o  = rdata0_q;
  assign r1_rdata_o  = rdata1_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_re_o    = mem_re_q;
  assign mem_we_o    = mem_we_q;
  assign mem_size_o  = mem_size_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors plus hand-written contention, field-change and reset-in-WAIT sequences.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [1:0]  r0_size = 0, r1_size = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0, mem_rdata = 0;
  logic        r0_gnt, r0_err, r0_rvalid, r1_gnt, r1_err, r1_rvalid, mem_re, mem_we, busy;
  logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_size_i(r0_size), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r0_gnt_o(r0_gnt), .r0_err_o(r0_err), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_size_i(r1_size), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r1_gnt_o(r1_gnt), .r1_err_o(r1_err), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_size_o(mem_size), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  typedef struct {
    logic        who;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        e_err;
    logic        e_re;
    logic        e_we;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic who, input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (who) begin
      r1_req = req; r1_we = we; r1_size = size; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_req = req; r0_we = we; r0_size = size; r0_addr = addr; r0_wdata = wdata;
    end
  endtask

  initial begin
    v[0] = '{1'b0, 1'b0, 2'b10, 32'h10000004, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    v[1] = '{1'b1, 1'b0, 2'b10, 32'h10000002, 32'h0,        32'h11112222, 1'b1, 1'b0, 1'b0};
    v[2] = '{1'b0, 1'b1, 2'b01, 32'h10000006, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 1'b1};
    v[3] = '{1'b1, 1'b1, 2'b00, 32'h10000003, 32'h000000A5, 32'h0,        1'b0, 1'b0, 1'b1};
    v[4] = '{1'b0, 1'b0, 2'b11, 32'h10000000, 32'h0,        32'h33334444, 1'b1, 1'b0, 1'b0};
    v[5] = '{1'b1, 1'b0, 2'b01, 32'h10000101, 32'h0,        32'h55556666, 1'b1, 1'b0, 1'b0};
    v[6] = '{1'b1, 1'b0, 2'b10, 32'h20000008, 32'h0,        32'h12345678, 1'b0, 1'b1, 1'b0};
    v[7] = '{1'b0, 1'b1, 2'b10, 32'h10000001, 32'h77778888, 32'h0,        1'b1, 1'b0, 1'b0};

    // reset state, with both stores already requesting
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h00000100, 32'h11111111);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h00000200, 32'h22222222);
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt, r0_err, r1_err, r0_rvalid, r1_rvalid}, 0);
    chk("rst_mem_en", {mem_re, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_size", mem_size, 0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 0);

    // contention: grants alternate r0, r1, r0, r1 on odd cycles after release
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        chk($sformatf("cont%0d_r0_gnt", k), r0_gnt, ((k - 1) / 2) % 2 == 0);
        chk($sformatf("cont%0d_r1_gnt", k), r1_gnt, ((k - 1) / 2) % 2 == 1);
        chk($sformatf("cont%0d_we", k), {mem_we, mem_re}, 2'b10);
        chk($sformatf("cont%0d_addr", k), mem_addr, ((k - 1) / 2) % 2 ? 32'h200 : 32'h100);
        chk($sformatf("cont%0d_wdata", k), mem_wdata, ((k - 1) / 2) % 2 ? 32'h22222222 : 32'h11111111);
      end else begin
        chk($sformatf("cont%0d_idle", k), {r0_gnt, r1_gnt, mem_we, busy}, 0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(v[i].who, 1'b1, v[i].we, v[i].size, v[i].addr, v[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), v[i].who ? r1_gnt : r0_gnt, 1);
      chk($sformatf("v%0d_gnt_other", i), v[i].who ? r0_gnt : r1_gnt, 0);
      chk($sformatf("v%0d_err", i), v[i].who ? r1_err : r0_err, v[i].e_err);
      chk($sformatf("v%0d_re", i), mem_re, v[i].e_re);
      chk($sformatf("v%0d_we", i), mem_we, v[i].e_we);
      chk($sformatf("v%0d_addr", i), mem_addr, v[i].addr);
      chk($sformatf("v%0d_size", i), mem_size, v[i].size);
      if (v[i].e_we) chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].wdata);
      chk($sformatf("v%0d_busy1", i), busy, 1);
      drive(v[i].who, 1'b0, v[i].we, v[i].size, v[i].addr, v[i].wdata);
      mem_rdata = v[i].mrdata;
      @(negedge clk);
      chk($sformatf("v%0d_busy2", i), busy, v[i].e_re);
      chk($sformatf("v%0d_rv2", i), {r0_rvalid, r1_rvalid, mem_re, mem_we}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), v[i].who ? r1_rvalid : r0_rvalid, v[i].e_re);
      chk($sformatf("v%0d_rvalid_other", i), v[i].who ? r0_rvalid : r1_rvalid, 0);
      if (v[i].e_re) chk($sformatf("v%0d_rdata", i), v[i].who ? r1_rdata : r0_rdata, v[i].mrdata);
      chk($sformatf("v%0d_busy3", i), busy, 0);
    end

    // r0 fields change while its load is in flight; held req becomes a new request after rvalid
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h10000010, 32'h0);
    @(negedge clk);
    chk("fc_gnt", r0_gnt, 1);
    mem_rdata = 32'h55AA55AA;
    r0_addr = 32'h10000020;
    @(negedge clk);
    chk("fc_addr_wait", mem_addr, 32'h10000010);
    chk("fc_gnt_wait", {r0_gnt, r1_gnt}, 0);
    @(negedge clk);
    chk("fc_r0_rvalid", r0_rvalid, 1);
    chk("fc_r1_rvalid", r1_rvalid, 0);
    chk("fc_r0_rdata", r0_rdata, 32'h55AA55AA);
    chk("fc_r1_rdata", r1_rdata, 32'h12345678);
    chk("fc_addr_rv", mem_addr, 32'h10000010);
    chk("fc_no_gnt", r0_gnt, 0);
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("fc_regnt", r0_gnt, 1);
    chk("fc_readdr", mem_addr, 32'h10000020);
    chk("fc_rere", mem_re, 1);
    r0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fc_rv2", r0_rvalid, 1);
    chk("fc_rdata2", r0_rdata, 32'h0BADF00D);

    // reset asserted while an r1 load sits in WAIT
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h00000040, 32'h0);
    @(negedge clk);
    chk("rw_gnt", r1_gnt, 1);
    r1_req = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_busy_rst", busy, 0);
    chk("rw_rdata_rst", {r0_rdata, r1_rdata}, 0);
    chk("rw_mem_rst", {mem_addr, mem_size, mem_re, mem_we}, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rw_no_rvalid%0d", k), {r0_rvalid, r1_rvalid}, 0);
      chk($sformatf("rw_r1_rdata%0d", k), r1_rdata, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
